// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Latency: n/a (types, constants and combinational helpers only).
// Backpressure: n/a.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Widest entry the merge helper handles; instances narrower than this
    // zero-extend into the helper and truncate the result back.
    localparam int MAX_W = 256;
    localparam int MAX_B = MAX_W / 8;

    typedef logic [MAX_W-1:0] word_t;
    typedef logic [MAX_B-1:0] be_t;

    // Number of byte lanes in an entry of width w.
    function automatic int nbytes(input int w);
        return w / 8;
    endfunction

    // Byte-merged word: lanes with be set come from new_w, others from old_w.
    function automatic word_t merge_be(input word_t old_w, input word_t new_w, input be_t be);
        word_t r;
        r = old_w;
        for (int i = 0; i < MAX_B; i++) begin
            if (be[i]) begin
                r[i*8 +: 8] = new_w[i*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: address mux, optional same-cycle write merge, output register.
// Latency: 1 cycle from rd_fire to rd_data.
// Backpressure: none; rd_fire is already qualified by enable and FSM state.
// Ports: clk/rst_n; rd_fire/rd_addr request; mem array view; wr_fire/wr_addr/
//        wr_data/wr_be of the concurrent write (consumed only with
//        REG_FILE_FWD_EN); rd_data registered result.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_fire,
    input  logic [AW-1:0]        rd_addr,
    input  logic [DATA_W-1:0]    mem [DEPTH],
    input  logic                 wr_fire,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [DATA_W/8-1:0]  wr_be,
    output logic [DATA_W-1:0]    rd_data
);

    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] sel;

    assign stored = mem[rd_addr];

`ifdef REG_FILE_FWD_EN
    // Write-first: a read of the address being written sees the merged word.
    assign sel = (wr_fire && (wr_addr == rd_addr))
               ? DATA_W'(merge_be(word_t'(stored), word_t'(wr_data), be_t'(wr_be)))
               : stored;
`else
    // Read-first: the stored value before this cycle's write is returned.
    logic unused_fwd;
    assign unused_fwd = ^{wr_fire, wr_addr, wr_data, wr_be};
    assign sel = stored;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_fire) begin
            rd_data <= sel;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: byte-enable write, NUM_RD registered reads,
// background clear sequencer (one entry per enabled cycle, DEPTH cycles).
// Latency: read 1 cycle (rd_valid pulses with rd_data); write visible next cycle.
// Backpressure: none; requests arriving while busy or with en=0 are dropped.
// Ports: clk, rst_n (async low), en; wr_en/wr_addr/wr_data/wr_be write;
//        rd_en/rd_addr (port k at [k*AW +: AW]) -> rd_data/rd_valid;
//        clr_req -> busy.
// Optional macro REG_FILE_FWD_EN: same-cycle read of the write address
//        returns the merged (write-first) value instead of the old value.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int NUM_RD = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic                     rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     clr_req,
    output logic                     busy
);

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [AW-1:0]     cnt;
    logic              wr_fire;
    logic              rd_fire;

    // Requests only take effect while enabled and not clearing.
    assign wr_fire = en && (state == IDLE) && wr_en;
    assign rd_fire = en && (state == IDLE) && rd_en;

    // Array, FSM and clear counter. A clear accepted in the same cycle as a
    // write still lets the write land; the sweep overwrites it later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        mem[wr_addr] <= DATA_W'(merge_be(word_t'(mem[wr_addr]),
                                                         word_t'(wr_data),
                                                         be_t'(wr_be)));
                    end
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[cnt] <= '0;
                    cnt      <= cnt + AW'(1);
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        reg_file_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_rd_port (
            .clk     (clk),
            .rst_n   (rst_n),
            .rd_fire (rd_fire),
            .rd_addr (rd_addr[k*AW +: AW]),
            .mem     (mem),
            .wr_fire (wr_fire),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .wr_be   (wr_be),
            .rd_data (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised + directed bench for reg_file_mp (DATA_W=32, DEPTH=16, NUM_RD=2)
// against an array-based reference model of the register file.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int DP = 16;
    localparam int NR = 2;
    localparam int AW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [3:0]     wr_be;
    logic           rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic           rd_valid;
    logic           clr_req;
    logic           busy;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    reg_file_mp #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0]    m_mem [DP];
    bit               m_busy;
    int               m_idx;
    logic [NR*DW-1:0] e_rd_data;
    bit               e_rd_valid;

    function automatic logic [DW-1:0] mrg(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [3:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DP; i++) m_mem[i] = '0;
            m_busy = 0; m_idx = 0; e_rd_data = '0; e_rd_valid = 0;
        end else if (!en) begin
            e_rd_valid = 0;
        end else if (m_busy) begin
            e_rd_valid = 0;
            m_mem[m_idx] = '0;
            m_idx++;
            if (m_idx == DP) m_busy = 0;
        end else begin
            if (rd_en) begin
                for (int k = 0; k < NR; k++) begin
                    int a;
                    logic [DW-1:0] v;
                    a = int'(rd_addr[k*AW +: AW]);
                    v = m_mem[a];
`ifdef REG_FILE_FWD_EN
                    if (wr_en && int'(wr_addr) == a) v = mrg(v, wr_data, wr_be);
`endif
                    e_rd_data[k*DW +: DW] = v;
                end
            end
            e_rd_valid = rd_en;
            if (wr_en) m_mem[wr_addr] = mrg(m_mem[wr_addr], wr_data, wr_be);
            if (clr_req) begin m_busy = 1; m_idx = 0; end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_on) begin
            chk("cyc_rd_valid", 64'(rd_valid), 64'(e_rd_valid));
            chk("cyc_busy", 64'(busy), 64'(m_busy));
            chk("cyc_rd_data", rd_data, e_rd_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        wr_en = 0; rd_en = 0; clr_req = 0; wr_be = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_be = be;
        step();
        wr_en = 0;
    endtask

    task automatic rd2(input int a0, input int a1);
        rd_en = 1; rd_addr = {AW'(a1), AW'(a0)};
        step();
        rd_en = 0;
    endtask

    task automatic fill();
        for (int i = 0; i < DP; i++) wr(i, 32'h1111_1111 * (i % 15 + 1) ^ 32'h0F00_0000, 4'hF);
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < DP; i++) begin
            rd2(i, DP - 1 - i);
            chk(name, rd_data, 64'h0);
            chk({name, "_vld"}, 64'(rd_valid), 64'h1);
        end
    endtask

    initial begin
        int n;
        rst_n = 0; en = 0; rd_addr = '0;
        quiet();
        step(); step();
        chk("rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_rd_data", rd_data, 64'h0);
        rst_n = 1; en = 1; cmp_on = 1;
        step();

        // Reset contents read back as zero; rd_valid is a one-cycle pulse.
        for (int a = 0; a < DP; a++) begin
            rd2(a, DP - 1 - a);
            chk("init_data", rd_data, 64'h0);
            chk("init_vld", 64'(rd_valid), 64'h1);
            step();
            chk("init_vld_drop", 64'(rd_valid), 64'h0);
        end

        // Byte-enable merge.
        wr(5, 32'hDEAD_BEEF, 4'b1111);
        wr(5, 32'h0000_00AA, 4'b0001);
        rd2(5, 0);
        chk("be_merge", 64'(rd_data[31:0]), 64'hDEAD_BEAA);

        // Same-cycle write/read collision.
        wr_en = 1; wr_addr = 3; wr_data = 32'h1234_5678; wr_be = 4'hF;
        rd_en = 1; rd_addr = {4'd3, 4'd0};
        step();
        quiet();
`ifdef REG_FILE_FWD_EN
        chk("collide_fwd", 64'(rd_data[63:32]), 64'h1234_5678);
`else
        chk("collide_nofwd", 64'(rd_data[63:32]), 64'h0);
`endif
        rd2(0, 3);
        chk("collide_next", 64'(rd_data[63:32]), 64'h1234_5678);

        // Full clear: busy for exactly DEPTH cycles, reads dropped meanwhile.
        fill();
        clr_req = 1; wr_en = 1; wr_addr = 2; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        step();
        quiet();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            rd_en = 1; wr_en = 1; rd_addr = AW'(n) * 8'h11;
            step();
            chk("clr_rd_valid", 64'(rd_valid), 64'h0);
        end
        quiet();
        chk("clr_busy_len", 64'(n), 64'd16);
        check_all_zero("clr_zero");

        // en=0 for 4 cycles at counter=7 freezes the sweep: 20 busy cycles.
        fill();
        clr_req = 1;
        step();
        quiet();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            en = !(n >= 8 && n <= 11);
            step();
        end
        en = 1;
        chk("frz_busy_len", 64'(n), 64'd20);
        check_all_zero("frz_zero");

        // Async reset at counter=9.
        fill();
        clr_req = 1; rd_en = 1; rd_addr = {4'd4, 4'd1};
        step();
        quiet();
        chk("pre_rst_data_nz", 64'(rd_data != 0), 64'h1);
        for (int i = 0; i < 9; i++) step();
        chk("pre_rst_busy", 64'(busy), 64'h1);
        #2 rst_n = 0;
        #1;
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_rd_data", rd_data, 64'h0);
        chk("arst_rd_valid", 64'(rd_valid), 64'h0);
        step();
        rst_n = 1;
        step();
        check_all_zero("arst_zero");

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            en      = ($urandom_range(0, 9) != 0);
            wr_en   = $urandom_range(0, 1);
            wr_addr = AW'($urandom_range(0, DP - 1));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            rd_en   = $urandom_range(0, 1);
            rd_addr = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rd_addr[3:0] = wr_addr;
            if ($urandom_range(0, 3) == 0) rd_addr[7:4] = rd_addr[3:0];
            clr_req = ($urandom_range(0, 59) == 0);
            step();
        end
        quiet(); en = 1;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file; next generation of the team's 16x32 two-read/one-write register file.
- Generalised in data width, depth and read-port count.
- Adds byte-enable writes, registered reads with a valid flag, and a background clear sequencer.
- Sits beside the datapath as the architectural register store; software-visible clear is driven from control.

Parameters:
DATA_W, 32, entry width in bits; must be a multiple of 8
DEPTH, 16, number of entries; power of two, >= 2
NUM_RD, 2, number of independent read ports, 1..4
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
en  in  1  global enable; when 0 the block holds all state
wr_en  in  1  write request
wr_addr  in  AW  write address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables for the write
rd_en  in  1  read request, applies to all ports
rd_addr  in  NUM_RD*AW  packed read addresses; port k at [k*AW +: AW]
rd_data  out  NUM_RD*DATA_W  packed registered read data
rd_valid  out  1  rd_data updated this cycle
clr_req  in  1  single-cycle request to clear the whole array
busy  out  1  clear sequence in progress

Behaviour:
- Reset (rst_n=0, async): all entries = 0, rd_data = 0, rd_valid = 0, busy = 0, FSM = IDLE, clear counter = 0. Never drives X.
- en=0: no write, no read, no clear; rd_data holds, rd_valid = 0, FSM and counter frozen.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR when en & clr_req. Counter = 0, busy = 1 from the next cycle.
  - CLEAR writes 0 to entry[counter] each enabled cycle and increments the counter.
  - CLEAR -> IDLE after the cycle that clears entry DEPTH-1. busy = 0 in the following cycle. Total DEPTH cycles.
  - clr_req while busy is ignored.
- Write (IDLE, en, wr_en): entry[wr_addr] byte i <= wr_data byte i where wr_be[i]=1; other bytes keep their value. wr_be = 0 is a no-op.
- Read (IDLE, en, rd_en): rd_data[k] <= entry[rd_addr[k]]. rd_valid = 1 for exactly the next cycle. Latency 1.
- During CLEAR: wr_en and rd_en are dropped (not queued); rd_valid = 0; rd_data holds.
- Same cycle as clr_req acceptance: a concurrent write or read in IDLE is still performed. The clear then overwrites the written entry.
- Multiple ports may read the same address; each port gets the same data.
- Read/write same-address collision: behaviour set by FWD_EN (below).
- Reset asserted mid-CLEAR: aborts immediately to reset state; remaining entries are reset to 0 anyway.

Optional Feature:
REG_FILE_FWD_EN
- Defined: a read hitting wr_addr in the same cycle returns the merged value. Enabled wr_data bytes are taken from wr_data; the other bytes come from the stored entry (write-first).
- Undefined: the read returns the pre-write stored value (read-first); the new value is visible from the next read.

Decomposition:
- Package reg_file_pkg:
  - state enum (IDLE, CLEAR)
  - byte-count constant helper
  - function merge_be(old, new, be) returning the byte-merged word, shared by the write path and forwarding.
- Sub-module reg_file_rd_port: one read mux, the optional forward merge and the output register. Instantiated NUM_RD times via generate.

Test Plan:
- Reset then read addr 0..15 on both ports -> rd_data all 0x00000000, rd_valid pulses one cycle after each rd_en.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x000000AA with be=4'b0001, then read port0=5 -> 0xDEADBEAA.
- Same cycle write 0x12345678 to addr 3 and read port1=3 (prior value 0) -> 0x12345678 with REG_FILE_FWD_EN, 0x00000000 without; next read -> 0x12345678 in both builds.
- Fill all 16 entries with nonzero data, pulse clr_req -> busy high for exactly 16 cycles; rd_en during busy -> rd_valid stays 0; afterwards every entry reads 0.
- Hold en=0 for 4 cycles mid-CLEAR at counter=7 -> counter frozen, busy stays 1; total busy duration 20 cycles.
- Assert rst_n=0 mid-CLEAR at counter=9 -> busy=0 and rd_data=0 immediately (async); all entries read 0 after release.
